// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock with valid/ready handshakes
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, dsh;
  logic [CW-1:0] cnt;
  logic br, d, br_n, last;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last = cnt == CW'(WIDTH - 1);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_n = (state == IDLE && in_valid)    ? SHIFT :
              (state == SHIFT && last)       ? DONE  :
              (state == DONE && out_ready)   ? IDLE  : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Result registers update only on the final bit so diff never shows a partial shift.
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      br <= 1'b0;
      sa <= '0;
      sb <= '0;
      dsh <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sa <= a;
      sb <= b;
      br <= bin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      br <= br_n;
      cnt <= cnt + 1'b1;
      dsh <= {d, dsh[WIDTH-1:1]};
      if (last) begin
        diff <= {d, dsh[WIDTH-1:1]};
        bout <= br_n;
        ovf <= br ^ br_n;
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (directed cases plus random stalls)
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic bin = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] diff;
  logic bout, ovf;
  typedef struct {logic [7:0] d; logic bo; logic ov;} exp_t;
  exp_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  bit rnd_rdy = 1'b0;
  bit rdy_force = 1'b1;
  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp_t e;
    logic [8:0] r;
    int s;
    r = {1'b0, x} - {1'b0, y} - {8'd0, c};
    s = int'($signed(x)) - int'($signed(y)) - int'({31'd0, c});
    e.d = r[7:0];
    e.bo = r[8];
    e.ov = (s < -128) || (s > 127);
    return e;
  endfunction
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] ed, input logic ebo, input logic eov);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 1);
    a = ta;
    b = tb;
    bin = tc;
    in_valid = 1'b1;
    e.d = ed;
    e.bo = ebo;
    e.ov = eov;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb;
    bin = ~tc;
  endtask
  initial forever begin
    @(posedge clk); #1;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      chk("queue_nonempty", {31'd0, q.size() != 0}, 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, e.d});
        chk("bout", {31'd0, bout}, {31'd0, e.bo});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
      end
    end
  initial begin
    int lat;
    int n;
    exp_t e;
    logic [7:0] ra, rb;
    logic rc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_diff", {24'd0, diff}, 0);
    chk("rst_bout", {31'd0, bout}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 8);
    send(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    send(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    send(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    send(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    rdy_force = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    send(8'hC3, 8'h41, 1'b0, 8'h82, 1'b0, 1'b0);
    a = 8'hFF;
    b = 8'h00;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_reached", {31'd0, out_valid}, 1);
    repeat (5) begin
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      chk("hold_diff", {24'd0, diff}, 32'h82);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_force = 1'b1;
    send(8'hA5, 8'h11, 1'b0, 8'h94, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 1);
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_diff", {24'd0, diff}, 0);
    q.delete();
    rst_n = 1'b1;
    send(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e = model(ra, rb, rc);
      send(ra, rb, rc, e.d, e.bo, e.ov);
    end
    rnd_rdy = 1'b0;
    rdy_force = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
